// File: rtl/f_fetch_queue_pkg.sv
// Shared constants and types for the fetch-to-decode queue.
package f_fetch_queue_pkg;

  // PC presented downstream while nothing valid is queued
  localparam logic [31:0] PC_RESET_DEF = 32'h0000_3000;
  // legal instruction-memory window, inclusive on both ends
  localparam logic [31:0] IM_BASE_DEF  = 32'h0000_3000;
  localparam logic [31:0] IM_LAST_DEF  = 32'h0000_6ffc;
  // substituted for the instruction of a faulting fetch
  localparam logic [31:0] NOP          = 32'h0000_0000;
  // CP0 ExcCode for an address error on load/fetch
  localparam logic [4:0]  EXC_ADEL     = 5'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        adel;
  } fq_entry_t;

endpackage

// File: rtl/f_fetch_queue_if.sv
// Fetch-side and decode-side handshake bundle of the fetch queue.
interface f_fetch_queue_if;
  logic        f_valid;
  logic [31:0] f_pc;
  logic [31:0] f_instr;
  logic        f_ready;
  logic        d_valid;
  logic        d_ready;
  logic [31:0] d_pc;
  logic [31:0] d_instr;
  logic        d_exc_adel;

  // master: the pipeline around the queue (fetch producer + decode consumer)
  modport master (
    output f_valid, f_pc, f_instr, d_ready,
    input  f_ready, d_valid, d_pc, d_instr, d_exc_adel
  );

  // slave: the queue itself
  modport slave (
    input  f_valid, f_pc, f_instr, d_ready,
    output f_ready, d_valid, d_pc, d_instr, d_exc_adel
  );
endinterface

// File: rtl/f_fetch_queue_adel_check.sv
// Combinational fetch-address legality check: misaligned or outside IM window.
module fq_adel_check
  import f_fetch_queue_pkg::*;
#(
  parameter logic [31:0] IM_BASE = IM_BASE_DEF,
  parameter logic [31:0] IM_LAST = IM_LAST_DEF
) (
  input  logic [31:0] pc,
  output logic        adel
);

  assign adel = (pc[1:0] != 2'b00) || (pc < IM_BASE) || (pc > IM_LAST);

endmodule

// File: rtl/f_fetch_queue.sv
// Fetch-to-decode instruction queue: circular buffer of {pc, instr, adel}.
// Optional zero-latency bypass when empty: define FQ_BYPASS_EN.
module f_fetch_queue
  import f_fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] PC_RESET = PC_RESET_DEF,
  parameter logic [31:0] IM_BASE  = IM_BASE_DEF,
  parameter logic [31:0] IM_LAST  = IM_LAST_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  f_fetch_queue_if.slave         fq,
  output logic [$clog2(DEPTH):0] count
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  fq_entry_t        mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic             adel, empty, full, bypass, push, pop;
  fq_entry_t        in_ent, head;

  fq_adel_check #(.IM_BASE(IM_BASE), .IM_LAST(IM_LAST)) u_adel (
    .pc  (fq.f_pc),
    .adel(adel)
  );

  // faulting fetches carry a nop so decode never sees garbage bits
  assign in_ent = '{pc: fq.f_pc, instr: (adel ? NOP : fq.f_instr), adel: adel};

  assign empty = (count == '0);
  assign full  = (count == CNT_FULL);

`ifdef FQ_BYPASS_EN
  // empty queue and a consumer waiting: hand the entry straight through
  assign bypass = empty && fq.f_valid && fq.d_ready && !flush;
`else
  assign bypass = 1'b0;
`endif

  // full blocks push even when a pop happens this cycle (f_ready is registered-only)
  assign push = fq.f_valid && !full && !bypass;
  assign pop  = !empty && fq.d_ready;
  assign head = mem[rd_ptr];

  assign fq.f_ready = !full;

  // head presentation; empty forces reset values rather than stale storage
  always_comb begin
    fq.d_valid    = !empty;
    fq.d_pc       = PC_RESET;
    fq.d_instr    = NOP;
    fq.d_exc_adel = 1'b0;
    if (!empty) begin
      fq.d_pc       = head.pc;
      fq.d_instr    = head.instr;
      fq.d_exc_adel = head.adel;
    end else if (bypass) begin
      fq.d_valid    = 1'b1;
      fq.d_pc       = in_ent.pc;
      fq.d_instr    = in_ent.instr;
      fq.d_exc_adel = in_ent.adel;
    end
  end

  // entry storage; contents are don't-care after reset/flush so no reset here
  always_ff @(posedge clk) begin
    if (push && !flush && !reset)
      mem[wr_ptr] <= in_ent;
  end

  // pointers and occupancy; reset and flush both empty the queue
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

endmodule

// File: doc/f_fetch_queue.md
Name: f_fetch_queue

Overview:
Fetch-to-decode instruction queue; sits directly downstream of the PC register and instruction memory, upstream of the D stage.
- Captures (PC, instruction) pairs produced in F and presents them in order to D with a valid/ready handshake.
- Decouples D-stage stalls from fetch, flushes on redirect, and tags address-error (AdEL) fetches.
- Its f_ready output drives the PC register's enable.

Parameters:
DEPTH, 4, number of queue entries; power of two, minimum 2
PC_RESET, 32'h0000_3000, PC value presented on d_pc when the queue is empty or in reset
IM_BASE, 32'h0000_3000, lowest legal fetch address
IM_LAST, 32'h0000_6ffc, highest legal fetch address (inclusive)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
f_valid  in  1  F stage offers an entry this cycle
f_pc  in  32  PC of offered entry
f_instr  in  32  instruction read from IM at f_pc
f_ready  out  1  queue can accept; drives PC enable
flush  in  1  discard all entries (branch/jump redirect, exception)
d_valid  out  1  head entry valid for D
d_ready  in  1  D accepts head this cycle (= not stall)
d_pc  out  32  head PC
d_instr  out  32  head instruction
d_exc_adel  out  1  head fetch was an address error
count  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (synchronous, active-high, clock clk):
  - count=0, read/write pointers=0, d_valid=0, f_ready=1.
  - d_pc=PC_RESET, d_instr=0, d_exc_adel=0.
  - Reset overrides every other input in the same cycle.
- Storage: circular buffer of DEPTH entries {pc[31:0], instr[31:0], adel}. Pointers are $clog2(DEPTH) bits and wrap naturally.
- Outputs:
  - f_ready = (count != DEPTH). Registered state only; no combinational path from d_ready.
  - d_valid = (count != 0).
- Push: f_valid && f_ready at a clock edge writes the entry at wr_ptr and advances wr_ptr.
- Pop: d_valid && d_ready at a clock edge advances rd_ptr.
- Simultaneous push and pop: count unchanged, both pointers advance. When full, push is blocked even if a pop occurs that cycle.
- Latency: a pushed entry is visible on d_* at the next cycle at the earliest. Order is strictly FIFO.
- AdEL tagging at push:
  - adel=1 when f_pc[1:0]!=0, or f_pc<IM_BASE, or f_pc>IM_LAST.
  - When adel=1, the stored instr is 0 (nop); stored pc = f_pc unchanged.
- Empty queue outputs: d_pc=PC_RESET, d_instr=0, d_exc_adel=0 (forced, not stale storage).
- Flush:
  - Next cycle: count=0, pointers=0, d_valid=0.
  - Flush has priority over push and pop in the same cycle; the offered f_* entry is dropped.
  - f_ready remains 1 during and after flush.
- Reset mid-operation: same effect as flush, plus d_pc=PC_RESET. Storage contents are don't-care.
- Count arithmetic: unsigned, width $clog2(DEPTH)+1. It must never exceed DEPTH or underflow. The bench asserts this.

Optional Feature:
Macro FQ_BYPASS_EN.
- Defined: when count==0 && f_valid && d_ready && !flush, the offered entry is forwarded combinationally to d_* with d_valid=1 and is not stored (zero-latency path). The AdEL rule applies to the forwarded entry. If d_ready=0, the entry is pushed normally.
- Undefined: no bypass; minimum latency is 1 cycle; d_valid depends only on registered count.

Decomposition:
- Shared package / macros.v holds:
  - PC_Reset (reuse existing macro for the PC_RESET default)
  - IM_BASE / IM_LAST address constants
  - NOP encoding 32'h0000_0000
  - AdEL exception code constant for downstream CP0
- One natural sub-module: fq_adel_check, a combinational legality check of f_pc producing adel. Storage and pointer logic stay in f_fetch_queue.

Test Plan:
- Reset, then push pc=0x3000/instr=0x3c010001 with d_ready=0 -> next cycle d_valid=1, d_pc=0x3000, d_instr=0x3c010001, count=1.
- Push 4 entries (0x3000..0x300c) with d_ready=0 -> count=4, f_ready=0. A fifth offer (0x3010) is ignored. Then d_ready=1 for 4 cycles -> d_pc sequence 0x3000, 0x3004, 0x3008, 0x300c; then d_valid=0, d_pc=0x3000.
- Full queue with f_valid=1 and d_ready=1 in the same cycle -> pop only, count=3. Next cycle push accepted, count stays 3.
- Push pc=0x3002 and pc=0x7000 -> both entries have d_exc_adel=1, d_instr=0, d_pc equal to the offered PC.
- Count=3 with flush=1, f_valid=1, d_ready=1 -> next cycle count=0, d_valid=0, f_ready=1, offered entry absent.
- FQ_BYPASS_EN defined: empty queue, f_valid=1, d_ready=1, pc=0x3020 -> same cycle d_valid=1, d_pc=0x3020; next cycle count=0.
